// File: rtl/jk_cmd_sequencer_pkg.sv
// Purpose: shared op codes, FSM states and j/k helpers for the JK command sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jk_seq_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Stored FIFO entry is {op, count} at full count width.
    function automatic int entry_width(input int cnt_w);
        return OP_W + cnt_w;
    endfunction

    // Map an op code onto the {j, k} levels that realise it.
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            OP_HOLD: jk = 2'b00;
            OP_RST:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            default: jk = 2'b11;
        endcase
        return jk;
    endfunction

    // Next q of an ideal JK flip-flop given its present q and inputs.
    function automatic logic jk_next_q(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Purpose: synchronous command FIFO with registered occupancy count.
// Latency: an entry written at edge t is visible at the head from edge t+1; no bypass.
// Backpressure: pushes while full and pops while empty are ignored; push and pop may coincide.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_dat_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic do_push;
    logic do_pop;

    assign do_push    = push_i && (level_q != LVL_W'(DEPTH));
    assign do_pop     = pop_i && (level_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks push minus pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Purpose: buffers {op, count} commands and replays each as registered j/k for count+1 edges, with a q reference model.
// Latency: command accepted at edge t drives j/k from edge t+1 through t+1+count; back-to-back commands have no bubble.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries; a push offered while full is ignored.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [CNT_W-1:0]         in_cnt,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic                     q_model,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ENTRY_W = entry_width(CNT_W);
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   rem_q;
    logic               j_q;
    logic               k_q;
    logic               q_model_q;

    logic [ENTRY_W-1:0] head_dat;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_nonempty;
    logic               pop;
    logic               push;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_cnt;

    assign fifo_nonempty       = (fifo_level != '0);
    assign in_ready            = (fifo_level != LVL_W'(DEPTH));
    assign push                = in_valid && in_ready;
    assign {head_op, head_cnt} = head_dat;

    // Pop whenever the driver is free to take a new command this edge.
    assign pop = fifo_nonempty && ((state_q == IDLE) || (rem_q == '0));

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({in_op, in_cnt}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .level_o    (fifo_level)
    );

    // Command driver FSM: loads j/k and repeat count on pop, counts down, idles with j=k=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_nonempty) begin
                        {j_q, k_q} <= op_to_jk(head_op);
                        rem_q      <= head_cnt;
                        state_q    <= DRIVE;
                    end else begin
                        j_q <= 1'b0;
                        k_q <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (rem_q != '0) begin
                        rem_q <= rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (fifo_nonempty) begin
                        {j_q, k_q} <= op_to_jk(head_op);
                        rem_q      <= head_cnt;
                    end else begin
                        j_q     <= 1'b0;
                        k_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    j_q     <= 1'b0;
                    k_q     <= 1'b0;
                end
            endcase
        end
    end

    // Reference q: what the downstream flip-flop will hold after sampling the current j/k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_model_q <= 1'b0;
        end else begin
            q_model_q <= jk_next_q(q_model_q, j_q, k_q);
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign q_model = q_model_q;
    assign busy    = (state_q == DRIVE);
    assign level   = fifo_level;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [CNT_W-1:0] in_cnt = '0;
    logic             j;
    logic             k;
    logic             busy;
    logic             q_model;
    logic [2:0]       level;

    int n_vec = 0;
    int n_err = 0;

    // Independent JK flip-flop standing in for the downstream jkff block.
    logic ff_q;
    logic [1:0] exp_q[$];

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_cnt   (in_cnt),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .q_model  (q_model),
        .level    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00: ff_q <= ff_q;
                2'b01: ff_q <= 1'b0;
                2'b10: ff_q <= 1'b1;
                default: ff_q <= ~ff_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        in_valid = v;
        in_op    = op;
        in_cnt   = cnt;
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] jk, input logic q, input logic b, input logic [2:0] lvl);
        chk({tag, "_jk"}, {30'd0, j, k}, {30'd0, jk});
        chk({tag, "_q"}, {31'd0, q_model}, {31'd0, q});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_lvl"}, {29'd0, level}, {29'd0, lvl});
    endtask

    initial begin
        bit found;
        logic [1:0] op_r;
        logic [CNT_W-1:0] cnt_r;

        // Reset state, then release between edges and watch an idle sequencer.
        #12;
        chk_outs("rst_hold", 2'b00, 1'b0, 1'b0, 3'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs("idle", 2'b00, 1'b0, 1'b0, 3'd0);
            chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        end

        // Single SET cnt=0: j/k for exactly one cycle, q_model one edge later.
        drive(1'b1, SET, 4'd0);
        step();
        drive(1'b0, HOLD, 4'd0);
        chk_outs("set0_t", 2'b00, 1'b0, 1'b0, 3'd1);
        step();
        chk_outs("set0_t1", 2'b10, 1'b0, 1'b1, 3'd0);
        step();
        chk_outs("set0_t2", 2'b00, 1'b1, 1'b0, 3'd0);
        step();
        chk_outs("set0_t3", 2'b00, 1'b1, 1'b0, 3'd0);

        // SET cnt=0 then TGL cnt=2 back to back: 10,11,11,11 with no bubble.
        drive(1'b1, SET, 4'd0);
        step();
        drive(1'b1, TGL, 4'd2);
        step();
        drive(1'b0, HOLD, 4'd0);
        chk_outs("b2b_1", 2'b10, 1'b1, 1'b1, 3'd1);
        step();
        chk_outs("b2b_2", 2'b11, 1'b1, 1'b1, 3'd0);
        step();
        chk_outs("b2b_3", 2'b11, 1'b0, 1'b1, 3'd0);
        step();
        chk_outs("b2b_4", 2'b11, 1'b1, 1'b1, 3'd0);
        step();
        chk_outs("b2b_5", 2'b00, 1'b0, 1'b0, 3'd0);
        step();
        chk_outs("b2b_6", 2'b00, 1'b0, 1'b0, 3'd0);

        // Stall on HOLD cnt=15 and fill the FIFO to DEPTH.
        drive(1'b1, HOLD, 4'd15);
        step();
        drive(1'b1, SET, 4'd0);
        step();
        drive(1'b1, RST, 4'd0);
        step();
        drive(1'b1, SET, 4'd0);
        step();
        drive(1'b1, RST, 4'd0);
        step();
        chk("full_lvl", {29'd0, level}, 32'd4);
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, TGL, 4'd0);
        step();
        chk("full_ign_lvl", {29'd0, level}, 32'd4);
        // Keep offering TGL; the first pop happens while full so the push is refused.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (level != 3'd4) found = 1'b1;
        end
        chk("full_pop_seen", {31'd0, found}, 32'd1);
        chk("full_pop_lvl", {29'd0, level}, 32'd3);
        chk("full_pop_jk", {30'd0, j, k}, 32'd2);
        // Now ready again: the TGL push coincides with the next pop, level unchanged.
        chk("pp_rdy", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, HOLD, 4'd0);
        chk("pp_lvl", {29'd0, level}, 32'd3);
        chk("pp_jk", {30'd0, j, k}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (!busy && level == 3'd0) found = 1'b1;
        end
        chk("drain_done", {31'd0, found}, 32'd1);

        // Reset in the middle of SET cnt=5 with RST cnt=3 still buffered.
        drive(1'b1, SET, 4'd5);
        step();
        drive(1'b1, RST, 4'd3);
        step();
        drive(1'b0, HOLD, 4'd0);
        step();
        chk_outs("pre_rst", 2'b10, 1'b1, 1'b1, 3'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_rst", 2'b00, 1'b0, 1'b0, 3'd0);
        chk("async_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_outs("post_rst", 2'b00, 1'b0, 1'b0, 3'd0);
        end

        // Random traffic: j/k stream against a queue of expected levels, q against the flip-flop.
        for (int i = 0; i < 500; i++) begin
            op_r  = 2'($urandom_range(0, 3));
            cnt_r = CNT_W'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), op_r, cnt_r);
            if (in_valid && in_ready) begin
                for (int c = 0; c <= int'(cnt_r); c++) exp_q.push_back(op_r);
            end
            step();
            chk("rnd_q", {31'd0, q_model}, {31'd0, ff_q});
            if (busy) begin
                if (exp_q.size() == 0) chk("rnd_underflow", 32'(exp_q.size()), 32'd1);
                else chk("rnd_jk", {30'd0, j, k}, {30'd0, exp_q.pop_front()});
            end else begin
                chk("rnd_idle_jk", {30'd0, j, k}, 32'd0);
            end
        end
        drive(1'b0, HOLD, 4'd0);
        for (int i = 0; i < 200 && (busy || exp_q.size() != 0); i++) begin
            step();
            chk("drn_q", {31'd0, q_model}, {31'd0, ff_q});
            if (busy && exp_q.size() != 0) chk("drn_jk", {30'd0, j, k}, {30'd0, exp_q.pop_front()});
        end
        chk("rnd_left", 32'(exp_q.size()), 32'd0);
        chk("rnd_busy_end", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
